// File: rtl/capture_unit.sv
// capture_unit: CSR-mapped input-capture peripheral.
// A prescaled free-running counter is sampled on each qualified edge of the
// synchronised cap_in pin and pushed into a small FIFO that software drains
// through the DATA CSR. irq flags pending captures when interrupts are enabled.
module capture_unit #(
    parameter logic [11:0] BaseAddr = 12'h400,
    parameter int          Depth    = 4,
    parameter int          TsWidth  = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        csr_enable,
    input  logic [11:0] csr_addr,
    input  logic [2:0]  csr_op,
    input  logic [4:0]  rs1_zimm,
    input  logic [31:0] rs1_data,
    input  logic        cap_in,
    output logic [31:0] out,
    output logic        irq
);

    localparam int          PtrW      = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [3:0]  DepthC    = 4'(Depth);
    localparam logic [15:0] CtrlMask  = 16'hFF17;
    localparam logic [11:0] AddrCtrl  = BaseAddr;
    localparam logic [11:0] AddrData  = BaseAddr + 12'd1;
    localparam logic [11:0] AddrStat  = BaseAddr + 12'd2;

    // Wrap a FIFO pointer at Depth (Depth need not be a power of two).
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        logic [PtrW-1:0] r;
        if (p == PtrW'(Depth - 1)) begin
            r = {PtrW{1'b0}};
        end else begin
            r = p + PtrW'(1);
        end
        return r;
    endfunction

    // Architectural state
    logic [15:0]        ctrl_r;
    logic [TsWidth-1:0] counter_r;
    logic [7:0]         presc_cnt_r;
    logic [TsWidth-1:0] mem_r [Depth];
    logic [PtrW-1:0]    rd_ptr_r;
    logic [PtrW-1:0]    wr_ptr_r;
    logic [3:0]         count_r;
    logic               ovf_r;
    logic               s1_r;
    logic               s2_r;
    logic               prev_r;

    // Decode / datapath signals
    logic [31:0] src_s;
    logic [31:0] wval_s;
    logic        op_valid_s;
    logic        access_s;
    logic        ctrl_we_s;
    logic        clr_s;
    logic        empty_s;
    logic        full_s;
    logic        pop_s;
    logic        event_s;
    logic        push_s;
    logic        ovf_set_s;
    logic        tick_s;
    logic [31:0] head_s;
    logic        unused_s;

    assign empty_s  = (count_r == 4'd0);
    assign full_s   = (count_r == DepthC);
    assign tick_s   = (presc_cnt_r == ctrl_r[15:8]);
    assign unused_s = ^wval_s[31:16];

    // CSR operation decode: source operand and value to be written to CTRL.
    always_comb begin
        src_s      = csr_op[2] ? {27'd0, rs1_zimm} : rs1_data;
        op_valid_s = 1'b0;
        wval_s     = {16'd0, ctrl_r};
        case (csr_op[1:0])
            2'b01: begin
                op_valid_s = 1'b1;
                wval_s     = src_s;
            end
            2'b10: begin
                op_valid_s = 1'b1;
                wval_s     = {16'd0, ctrl_r} | src_s;
            end
            2'b11: begin
                op_valid_s = 1'b1;
                wval_s     = {16'd0, ctrl_r} & ~src_s;
            end
            default: begin
                op_valid_s = 1'b0;
                wval_s     = {16'd0, ctrl_r};
            end
        endcase
    end

    // Access qualification, edge detection and FIFO push/pop decisions.
    always_comb begin
        access_s  = csr_enable & op_valid_s;
        ctrl_we_s = access_s & (csr_addr == AddrCtrl);
        clr_s     = ctrl_we_s & wval_s[3];
        pop_s     = access_s & (csr_addr == AddrData) & ~empty_s;
        event_s   = ctrl_r[0] & ((ctrl_r[1] & s2_r & ~prev_r) |
                                 (ctrl_r[2] & ~s2_r & prev_r));
        // clr discards any coincident capture; a pop makes room in a full FIFO.
        push_s    = event_s & ~clr_s & (~full_s | pop_s);
        ovf_set_s = event_s & ~clr_s & full_s & ~pop_s;
    end

    // Zero-extended FIFO head, 0 when empty.
    always_comb begin
        head_s = 32'd0;
        if (!empty_s) begin
            head_s[TsWidth-1:0] = mem_r[rd_ptr_r];
        end else begin
            head_s = 32'd0;
        end
    end

    // Read mux: pre-write value of the addressed CSR, 0 when idle or unmapped.
    always_comb begin
        out = 32'd0;
        if (access_s) begin
            case (csr_addr)
                AddrCtrl: out = {16'd0, ctrl_r};
                AddrData: out = head_s;
                AddrStat: out = {23'd0, ovf_r, 2'b00, full_s, empty_s, count_r};
                default:  out = 32'd0;
            endcase
        end else begin
            out = 32'd0;
        end
    end

    assign irq = ctrl_r[4] & ~empty_s;

    // CTRL register; clr is never stored so it always reads back 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_r <= 16'd0;
        end else if (ctrl_we_s) begin
            ctrl_r <= wval_s[15:0] & CtrlMask;
        end else begin
            ctrl_r <= ctrl_r;
        end
    end

    // Prescaler and timestamp counter; both frozen while disabled.
    always_ff @(posedge clk) begin
        if (reset || clr_s) begin
            presc_cnt_r <= 8'd0;
            counter_r   <= {TsWidth{1'b0}};
        end else if (ctrl_r[0]) begin
            if (tick_s) begin
                presc_cnt_r <= 8'd0;
                counter_r   <= counter_r + TsWidth'(1);
            end else begin
                presc_cnt_r <= presc_cnt_r + 8'd1;
            end
        end else begin
            presc_cnt_r <= presc_cnt_r;
        end
    end

    // Two-flop synchroniser plus history flop; runs regardless of en.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_r   <= 1'b0;
            s2_r   <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            s1_r   <= cap_in;
            s2_r   <= s1_r;
            prev_r <= s2_r;
        end
    end

    // FIFO storage; contents are only meaningful below count_r.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= counter_r;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset || clr_s) begin
            rd_ptr_r <= {PtrW{1'b0}};
            wr_ptr_r <= {PtrW{1'b0}};
            count_r  <= 4'd0;
            ovf_r    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 4'd1;
                2'b01:   count_r <= count_r - 4'd1;
                default: count_r <= count_r;
            endcase
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

endmodule
